// File: rtl/leg_core_param.sv
// leg_core_param: parametrised register-machine CPU core.
// Instructions are {dest, arg2, arg1, opcode} fetched from an external
// synchronous instruction memory. A FETCH/EXEC control FSM sequences each
// instruction, with run/step/halt control and valid/ready I/O handshakes.
// Optional build macro: LEG_SIGNED_CMP_EN adds signed branch funcs 6..9.
module leg_core_param #(
  parameter int DATA_W      = 8,
  parameter int NREGS       = 6,
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 16,
  parameter int RAM_DEPTH   = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [PC_W-1:0]         imem_addr,
  input  logic [8+3*DATA_W-1:0]   imem_data,
  input  logic                    run,
  input  logic                    step,
  output logic                    halted,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    stack_err,
  output logic [PC_W-1:0]         pc_monitor,
  output logic [NREGS*DATA_W-1:0] reg_monitor
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int RA_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [7:0] OPD_PC    = 8'd16;
  localparam logic [7:0] OPD_IO    = 8'd17;
  localparam logic [7:0] OPD_RAM   = 8'd18;
  localparam logic [7:0] OPD_RADDR = 8'd19;
  localparam logic [7:0] OPD_STK   = 8'd20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_OUTW  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   raddr_q, raddr_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   stack_mem [STACK_DEPTH];
  logic [DATA_W-1:0]   ram_mem [RAM_DEPTH];

  // Operand source mux: literal, register, or one of the special codes.
  function automatic logic [DATA_W-1:0] src_sel(
    input logic                    imm,
    input logic [DATA_W-1:0]       fld,
    input logic [NREGS*DATA_W-1:0] regs,
    input logic [PC_W-1:0]         pc,
    input logic [DATA_W-1:0]       io,
    input logic [DATA_W-1:0]       ram,
    input logic [DATA_W-1:0]       ra,
    input logic [DATA_W-1:0]       top
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (imm) begin
      v = fld;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (fld[7:0] == 8'(r)) v = regs[r*DATA_W +: DATA_W];
      end
      case (fld[7:0])
        OPD_PC:    v = DATA_W'(pc);
        OPD_IO:    v = io;
        OPD_RAM:   v = ram;
        OPD_RADDR: v = ra;
        OPD_STK:   v = top;
        default:   ;
      endcase
    end
    return v;
  endfunction

  // Instruction field split
  logic [7:0]        opc_s, code1_s, code2_s, dcode_s;
  logic [DATA_W-1:0] fld1_s, fld2_s, fldd_s;
  logic              imm1_s, imm2_s, cond_s;
  logic [4:0]        func_s;

  assign opc_s   = imem_data[7:0];
  assign fld1_s  = imem_data[8 +: DATA_W];
  assign fld2_s  = imem_data[8+DATA_W +: DATA_W];
  assign fldd_s  = imem_data[8+2*DATA_W +: DATA_W];
  assign imm1_s  = opc_s[7];
  assign imm2_s  = opc_s[6];
  assign cond_s  = opc_s[5];
  assign func_s  = opc_s[4:0];
  assign code1_s = fld1_s[7:0];
  assign code2_s = fld2_s[7:0];
  assign dcode_s = fldd_s[7:0];

  logic [NREGS*DATA_W-1:0] reg_flat_s;
  logic                    stk_empty_s, stk_full_s;
  logic [SI_W-1:0]         top_idx_s;
  logic [DATA_W-1:0]       stk_top_s, ram_rd_s;
  logic [DATA_W-1:0]       a1_s, a2_s, alu_s, push_val_s;
  logic                    take_s;
  logic                    alu_op_s, is_call_s, is_ret_s, is_halt_s;
  logic                    need_in_s, pop_req_s, push_req_s, commit_s;
  logic                    wr_out_s;
  logic [SP_W-1:0]         sp_pop_s;
  logic [PC_W-1:0]         pc_inc_s;

  // Flatten the register file for the monitor port and the source mux.
  always_comb begin
    reg_flat_s = '0;
    for (int r = 0; r < NREGS; r++) reg_flat_s[r*DATA_W +: DATA_W] = regs_q[r];
  end

  assign stk_empty_s = (sp_q == '0);
  assign top_idx_s   = SI_W'(sp_q - SP_W'(1));
  assign stk_top_s   = stk_empty_s ? '0 : stack_mem[top_idx_s];
  assign ram_rd_s    = ram_mem[raddr_q[RA_W-1:0]];

  assign a1_s = src_sel(imm1_s, fld1_s, reg_flat_s, pc_q, in_data, ram_rd_s, raddr_q, stk_top_s);
  assign a2_s = src_sel(imm2_s, fld2_s, reg_flat_s, pc_q, in_data, ram_rd_s, raddr_q, stk_top_s);

  assign alu_op_s  = !cond_s && (func_s < 5'd8);
  assign is_call_s = !cond_s && (func_s == 5'd8);
  assign is_ret_s  = !cond_s && (func_s == 5'd9);
  assign is_halt_s = !cond_s && (func_s == 5'd10);
  assign need_in_s = (!imm1_s && code1_s == OPD_IO) || (!imm2_s && code2_s == OPD_IO);
  assign pop_req_s = (!imm1_s && code1_s == OPD_STK) || (!imm2_s && code2_s == OPD_STK) || is_ret_s;
  assign commit_s  = (state_q == S_EXEC) && (!need_in_s || in_valid);
  assign wr_out_s  = alu_op_s && (dcode_s == OPD_IO);
  assign pc_inc_s  = pc_q + PC_W'(1);

  // Pop is applied first, so a push in the same instruction lands on the popped slot.
  assign sp_pop_s   = (pop_req_s && !stk_empty_s) ? sp_q - SP_W'(1) : sp_q;
  assign stk_full_s = (sp_pop_s == SP_W'(STACK_DEPTH));
  assign push_req_s = (alu_op_s && dcode_s == OPD_STK) || is_call_s;
  assign push_val_s = is_call_s ? DATA_W'(pc_inc_s) : alu_s;

  // ALU result for funcs 0..7
  always_comb begin
    alu_s = '0;
    case (func_s[2:0])
      3'd0:    alu_s = a1_s + a2_s;
      3'd1:    alu_s = a1_s - a2_s;
      3'd2:    alu_s = a1_s & a2_s;
      3'd3:    alu_s = a1_s | a2_s;
      3'd4:    alu_s = ~a1_s;
      3'd5:    alu_s = a1_s ^ a2_s;
      3'd6:    alu_s = a1_s << a2_s[2:0];
      default: alu_s = a1_s >> a2_s[2:0];
    endcase
  end

  // Branch condition evaluation
  always_comb begin
    take_s = 1'b0;
    case (func_s)
      5'd0:    take_s = (a1_s == a2_s);
      5'd1:    take_s = (a1_s != a2_s);
      5'd2:    take_s = (a1_s <  a2_s);
      5'd3:    take_s = (a1_s <= a2_s);
      5'd4:    take_s = (a1_s >  a2_s);
      5'd5:    take_s = (a1_s >= a2_s);
`ifdef LEG_SIGNED_CMP_EN
      5'd6:    take_s = ($signed(a1_s) <  $signed(a2_s));
      5'd7:    take_s = ($signed(a1_s) <= $signed(a2_s));
      5'd8:    take_s = ($signed(a1_s) >  $signed(a2_s));
      5'd9:    take_s = ($signed(a1_s) >= $signed(a2_s));
`endif
      default: take_s = 1'b0;
    endcase
  end

  // Next-state logic for the control FSM and all scalar architectural state
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    raddr_d    = raddr_q;
    sp_d       = sp_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
        else             state_d = S_IDLE;
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (commit_s) begin
          if (cond_s) begin
            if (take_s) pc_d = fldd_s[PC_W-1:0];
            else        pc_d = pc_inc_s;
          end else if (alu_op_s && dcode_s == OPD_PC) begin
            pc_d = alu_s[PC_W-1:0];
          end else if (is_call_s) begin
            pc_d = a1_s[PC_W-1:0];
          end else if (is_ret_s) begin
            pc_d = stk_top_s[PC_W-1:0];
          end else begin
            pc_d = pc_inc_s;
          end
          if (alu_op_s && dcode_s == OPD_RADDR) raddr_d = alu_s;
          else                                  raddr_d = raddr_q;
          if (wr_out_s) out_data_d = alu_s;
          else          out_data_d = out_data_q;
          if (push_req_s && !stk_full_s) sp_d = sp_pop_s + SP_W'(1);
          else                           sp_d = sp_pop_s;
          if ((pop_req_s && stk_empty_s) || (push_req_s && stk_full_s)) err_d = 1'b1;
          else                                                          err_d = err_q;
          if (is_halt_s)     state_d = S_HALT;
          else if (wr_out_s) state_d = S_OUTW;
          else if (run)      state_d = S_FETCH;
          else               state_d = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_OUTW: begin
        if (out_ready) state_d = run ? S_FETCH : S_IDLE;
        else           state_d = S_OUTW;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Scalar state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      raddr_q    <= '0;
      sp_q       <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      raddr_q    <= raddr_d;
      sp_q       <= sp_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  // General register file, written by ALU ops at commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (commit_s && alu_op_s && dcode_s == 8'(r)) regs_q[r] <= alu_s;
      end
    end
  end

  // Data RAM write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (commit_s && alu_op_s && dcode_s == OPD_RAM) ram_mem[raddr_q[RA_W-1:0]] <= alu_s;
  end

  // Stack storage; a push onto a full stack is dropped
  always_ff @(posedge clk) begin
    if (commit_s && push_req_s && !stk_full_s) stack_mem[SI_W'(sp_pop_s)] <= push_val_s;
  end

  assign imem_addr   = pc_q;
  assign pc_monitor  = pc_q;
  assign reg_monitor = reg_flat_s;
  assign halted      = (state_q == S_HALT);
  assign out_valid   = (state_q == S_OUTW);
  assign out_data    = out_data_q;
  assign in_ready    = (state_q == S_EXEC) && need_in_s;
  assign stack_err   = err_q;

endmodule

// File: doc/leg_core_param.md
Name: leg_core_param

Overview:
- Parametrised successor of the 8-bit register-machine CPU, as a single block.
- Executes 4-field instructions {dest, arg2, arg1, opcode} from an external synchronous instruction memory.
- Register file width and count are parameters; internal stack and RAM depths are parameters.
- Adds a FETCH/EXEC control FSM, run/step/halt control, valid/ready I/O handshakes and a sticky stack-error flag.

Parameters:
DATA_W, 8, datapath and operand-field width (>= 8)
NREGS, 6, general registers R0..NREGS-1 (1..16)
PC_W, 8, program counter width (PC_W <= DATA_W)
STACK_DEPTH, 16, stack entries
RAM_DEPTH, 256, data RAM words (power of 2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
imem_addr  out  PC_W  instruction word address (= PC)
imem_data  in  8+3*DATA_W  instruction, valid 1 cycle after imem_addr
run  in  1  level: execute continuously
step  in  1  1-cycle pulse: execute one instruction
halted  out  1  HALT executed
in_data  in  DATA_W  input operand
in_valid  in  1  input available
in_ready  out  1  core consuming input
out_data  out  DATA_W  output value
out_valid  out  1  output pending
out_ready  in  1  sink accepts output
stack_err  out  1  sticky overflow/underflow
pc_monitor  out  PC_W  current PC
reg_monitor  out  NREGS*DATA_W  register file, R0 in LSBs

Behaviour:
- Reset: PC=0; all regs=0; RAM address reg=0; stack empty; state IDLE; halted=0, in_ready=0, out_valid=0, out_data=0, stack_err=0. RAM contents not reset.
- Opcode byte:
  - [7] imm1: arg1 field is a literal. [6] imm2: arg2 field is a literal.
  - [5] cond: compare-and-branch. [4:0] func.
- Operand codes (field low 8 bits, when not literal):
  - 0..NREGS-1 = Rn; 16 = PC; 17 = I/O; 18 = RAM[raddr]; 19 = raddr; 20 = stack top.
  - Other codes read 0; writes to them are discarded.
- ALU, cond=0, func: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT arg1, 5 XOR, 6 SHL arg1 by arg2[2:0], 7 SHR likewise.
  - Result is modulo 2^DATA_W and is written to dest.
  - dest=PC performs a jump to result[PC_W-1:0].
- Special ops, cond=0:
  - func 8 CALL: push PC+1, PC<=arg1.
  - func 9 RET: pop into PC.
  - func 10 HALT.
  - Funcs 11..31 are NOPs.
- Branch, cond=1, unsigned compare of arg1 vs arg2: func 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE.
  - True: PC<=dest field[PC_W-1:0]. False: PC+1.
  - Funcs 6..31 never branch.
- FSM states: IDLE, FETCH, EXEC, OUTW, HALT.
  - IDLE: go to FETCH if run or step.
  - FETCH: drive imem_addr=PC; go to EXEC.
  - EXEC: decode imem_data and commit all writes in one cycle.
    - Default next PC = PC+1, wrapping at 2^PC_W.
    - If dest is I/O: latch out_data and go to OUTW.
    - Otherwise go to FETCH if run, else IDLE. A step therefore executes exactly one instruction.
  - OUTW: out_valid=1 with out_data stable; on out_ready go to FETCH/IDLE by the same rule.
  - HALT: halted=1. run and step are ignored; exit only via rst.
- Minimum 2 cycles per instruction.
- Input stall:
  - In EXEC, if any source operand is I/O, in_ready=1.
  - The core holds EXEC with no state change until in_valid.
  - One transfer per instruction; both I/O operands receive the same value.
- Stack:
  - Any stack-source operand pops once; both stack operands see the same top.
  - Pop happens before push in the same instruction, so arg=stack with dest=stack replaces the top.
  - Push when full: value discarded, stack_err<=1.
  - Pop when empty: value reads 0, stack_err<=1. RET on empty stack jumps to 0.
- RAM:
  - Combinational read of RAM[raddr mod RAM_DEPTH]; write at EXEC commit.
  - raddr is written like a register.
- Register as source and dest in the same instruction: the old value is read and the new value is written at the clock edge.
- rst mid-instruction, including OUTW: abort immediately to reset values. A pending output is dropped.

Optional Feature:
- Macro LEG_SIGNED_CMP_EN.
- Defined: branch funcs 6..9 = signed LT, LE, GT, GE (two's complement, DATA_W bits).
- Undefined: funcs 6..9 never branch and no signed-compare logic is built.

Test Plan:
1. rst, run=1; imem[0] = ADD imm1 imm2 5,3 -> R0 -> reg_monitor R0=8 in cycle 2 after run; pc_monitor=1.
2. R0=8; BEQ R0, imm 8, dest 5 -> PC=5. Same with imm 7 -> PC=PC+1.
3. ADD I/O, imm 1 -> I/O. Hold in_valid=0 for 3 cycles, then in_data=0x41 -> in_ready high throughout the stall, no PC change. Then out_data=0x42, out_valid held until out_ready, and FETCH follows on the next cycle.
4. CALL imm 10 at PC=2, RET at PC=10 -> PC 10 then 3; stack empty; stack_err=0.
5. STACK_DEPTH=4: 5 pushes -> stack_err=1 and 4 entries kept. Then 5 pops -> 4 original values, then 0. stack_err stays 1 until rst.
6. run=0: one step pulse -> exactly one instruction then IDLE. HALT -> halted=1; further run/step leave PC unchanged; rst clears halted and PC.
